// File: rtl/rs_mul_station_pkg.sv
// Shared widths and helpers for the multiply reservation station.
// Station defaults live here alongside the core datapath widths.
package rs_mul_station_pkg;

    localparam int DATA_LEN       = 32;
    localparam int SPECTAG_LEN    = 5;
    localparam int RRF_SEL        = 6;
    localparam int RS_MUL_ENT_NUM = 2;
    localparam int RS_MUL_ENT_SEL = 1;

    function automatic logic tag_hit(input logic [SPECTAG_LEN-1:0] a,
                                     input logic [SPECTAG_LEN-1:0] b);
        return |(a & b);
    endfunction

    // Returns {ready, value}. A waiting operand holds its RRF tag in the low bits;
    // wb0 is checked first so it wins when both buses carry the same tag.
    function automatic logic [DATA_LEN:0] snoop(input logic                rdy,
                                                input logic [DATA_LEN-1:0] src,
                                                input logic                e0,
                                                input logic [RRF_SEL-1:0]  t0,
                                                input logic [DATA_LEN-1:0] d0,
                                                input logic                e1,
                                                input logic [RRF_SEL-1:0]  t1,
                                                input logic [DATA_LEN-1:0] d1);
        logic [DATA_LEN:0] res;
        res = {rdy, src};
        if (!rdy) begin
            if (e0 && (t0 == src[RRF_SEL-1:0]))
                res = {1'b1, d0};
            else if (e1 && (t1 == src[RRF_SEL-1:0]))
                res = {1'b1, d1};
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_mul_select.sv
// Lowest-index-first picker: request vector in, grant flag and index out.
// Used both for free-entry allocation and for issue selection.
module rs_mul_select
    import rs_mul_station_pkg::*;
#(
    parameter int ENTRY_NUM = RS_MUL_ENT_NUM,
    parameter int ENT_SEL   = RS_MUL_ENT_SEL
) (
    input  logic [ENTRY_NUM-1:0] req,
    output logic                 grant,
    output logic [ENT_SEL-1:0]   idx
);

    always_comb begin
        grant = 1'b0;
        idx   = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant = 1'b1;
                idx   = ENT_SEL'(i);
            end
        end
    end

endmodule

// File: rtl/rs_mul_station.sv
// Reservation station for the integer multiply pipe: holds dispatched ops,
// snoops two result buses, issues one ready op per cycle, honours branch kill/confirm.
module rs_mul_station
    import rs_mul_station_pkg::*;
#(
    parameter int ENTRY_NUM = RS_MUL_ENT_NUM,
    parameter int ENT_SEL   = RS_MUL_ENT_SEL
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dp_valid,
    output logic                   dp_ready,
    input  logic [DATA_LEN-1:0]    dp_src1,
    input  logic [DATA_LEN-1:0]    dp_src2,
    input  logic                   dp_rdy1,
    input  logic                   dp_rdy2,
    input  logic [RRF_SEL-1:0]     dp_dst,
    input  logic                   dp_dstval,
    input  logic [SPECTAG_LEN-1:0] dp_spectag,
    input  logic                   dp_specbit,
    input  logic                   dp_s1s,
    input  logic                   dp_s2s,
    input  logic                   dp_lohi,
    input  logic                   wb0_en,
    input  logic [RRF_SEL-1:0]     wb0_tag,
    input  logic [DATA_LEN-1:0]    wb0_data,
    input  logic                   wb1_en,
    input  logic [RRF_SEL-1:0]     wb1_tag,
    input  logic [DATA_LEN-1:0]    wb1_data,
    input  logic                   prmiss,
    input  logic                   prsuccess,
    input  logic [SPECTAG_LEN-1:0] spectagfix,
    input  logic                   iss_en,
    output logic                   iss_valid,
    output logic [DATA_LEN-1:0]    iss_src1,
    output logic [DATA_LEN-1:0]    iss_src2,
    output logic [RRF_SEL-1:0]     iss_dst,
    output logic                   iss_dstval,
    output logic [SPECTAG_LEN-1:0] iss_spectag,
    output logic                   iss_specbit,
    output logic                   iss_s1s,
    output logic                   iss_s2s,
    output logic                   iss_lohi
);

    // Handshakes: an op is accepted when dp_valid & dp_ready at the edge; an op
    // leaves when iss_valid is high, which already includes iss_en, so downstream
    // takes it unconditionally in that cycle.
    logic [ENTRY_NUM-1:0] valid, rdy1, rdy2, dstval, specbit, s1s, s2s, lohi;
    logic [DATA_LEN-1:0]    src1    [ENTRY_NUM];
    logic [DATA_LEN-1:0]    src2    [ENTRY_NUM];
    logic [RRF_SEL-1:0]     dst     [ENTRY_NUM];
    logic [SPECTAG_LEN-1:0] spectag [ENTRY_NUM];

    logic [DATA_LEN:0]    ent_w1 [ENTRY_NUM];
    logic [DATA_LEN:0]    ent_w2 [ENTRY_NUM];
    logic [DATA_LEN:0]    dp_w1, dp_w2;
    logic [ENTRY_NUM-1:0] kill, eligible;
    logic                 free_grant, iss_grant, dp_kill, dp_write, success;
    logic [ENT_SEL-1:0]   free_idx, iss_idx;

    // prmiss outranks prsuccess if both are ever raised together.
    assign success  = prsuccess & ~prmiss;
    assign dp_kill  = prmiss & dp_specbit & tag_hit(dp_spectag, spectagfix);
    assign dp_ready = free_grant;
    assign dp_write = dp_valid & dp_ready & ~dp_kill;
    assign dp_w1    = snoop(dp_rdy1, dp_src1, wb0_en, wb0_tag, wb0_data, wb1_en, wb1_tag, wb1_data);
    assign dp_w2    = snoop(dp_rdy2, dp_src2, wb0_en, wb0_tag, wb0_data, wb1_en, wb1_tag, wb1_data);

    always_comb begin
        for (int i = 0; i < ENTRY_NUM; i++) begin
            kill[i]     = prmiss & specbit[i] & tag_hit(spectag[i], spectagfix);
            eligible[i] = valid[i] & rdy1[i] & rdy2[i] & ~kill[i];
            ent_w1[i]   = snoop(rdy1[i], src1[i], wb0_en, wb0_tag, wb0_data, wb1_en, wb1_tag, wb1_data);
            ent_w2[i]   = snoop(rdy2[i], src2[i], wb0_en, wb0_tag, wb0_data, wb1_en, wb1_tag, wb1_data);
        end
    end

    rs_mul_select #(.ENTRY_NUM(ENTRY_NUM), .ENT_SEL(ENT_SEL)) u_alloc (
        .req   (~valid),
        .grant (free_grant),
        .idx   (free_idx)
    );

    rs_mul_select #(.ENTRY_NUM(ENTRY_NUM), .ENT_SEL(ENT_SEL)) u_issue (
        .req   (eligible),
        .grant (iss_grant),
        .idx   (iss_idx)
    );

    assign iss_valid = iss_en & iss_grant;

    always_comb begin
        iss_src1    = '0;
        iss_src2    = '0;
        iss_dst     = '0;
        iss_dstval  = 1'b0;
        iss_spectag = '0;
        iss_specbit = 1'b0;
        iss_s1s     = 1'b0;
        iss_s2s     = 1'b0;
        iss_lohi    = 1'b0;
        if (iss_valid) begin
            iss_src1    = src1[iss_idx];
            iss_src2    = src2[iss_idx];
            iss_dst     = dst[iss_idx];
            iss_dstval  = dstval[iss_idx];
            iss_spectag = spectag[iss_idx];
            iss_specbit = specbit[iss_idx];
            iss_s1s     = s1s[iss_idx];
            iss_s2s     = s2s[iss_idx];
            iss_lohi    = lohi[iss_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid   <= '0;
            rdy1    <= '0;
            rdy2    <= '0;
            dstval  <= '0;
            specbit <= '0;
            s1s     <= '0;
            s2s     <= '0;
            lohi    <= '0;
            for (int i = 0; i < ENTRY_NUM; i++) begin
                src1[i]    <= '0;
                src2[i]    <= '0;
                dst[i]     <= '0;
                spectag[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                if (kill[i] || (iss_valid && (iss_idx == ENT_SEL'(i)))) begin
                    valid[i] <= 1'b0;
                end else if (valid[i]) begin
                    rdy1[i] <= ent_w1[i][DATA_LEN];
                    src1[i] <= ent_w1[i][DATA_LEN-1:0];
                    rdy2[i] <= ent_w2[i][DATA_LEN];
                    src2[i] <= ent_w2[i][DATA_LEN-1:0];
                    if (success && tag_hit(spectag[i], spectagfix))
                        specbit[i] <= 1'b0;
                end
            end
            // The allocated slot is always currently free, so it never collides
            // with a kill or issue of a live entry above.
            if (dp_write) begin
                valid[free_idx]   <= 1'b1;
                rdy1[free_idx]    <= dp_w1[DATA_LEN];
                src1[free_idx]    <= dp_w1[DATA_LEN-1:0];
                rdy2[free_idx]    <= dp_w2[DATA_LEN];
                src2[free_idx]    <= dp_w2[DATA_LEN-1:0];
                dst[free_idx]     <= dp_dst;
                dstval[free_idx]  <= dp_dstval;
                spectag[free_idx] <= dp_spectag;
                specbit[free_idx] <= dp_specbit & ~(success & tag_hit(dp_spectag, spectagfix));
                s1s[free_idx]     <= dp_s1s;
                s2s[free_idx]     <= dp_s2s;
                lohi[free_idx]    <= dp_lohi;
            end
        end
    end

endmodule

// File: tb/tb_rs_mul_station.sv
// Bench for rs_mul_station: directed scenarios plus a randomized run, all checked
// against a cycle-level behavioural model of the station kept in the bench.
module tb_rs_mul_station;
    import rs_mul_station_pkg::*;

    localparam int NE = RS_MUL_ENT_NUM;
    localparam int W  = 80;

    logic        clk = 1'b0;
    logic        reset;
    logic        dp_valid, dp_ready, dp_rdy1, dp_rdy2, dp_dstval, dp_specbit, dp_s1s, dp_s2s, dp_lohi;
    logic [31:0] dp_src1, dp_src2, wb0_data, wb1_data;
    logic [5:0]  dp_dst, wb0_tag, wb1_tag;
    logic [4:0]  dp_spectag, spectagfix;
    logic        wb0_en, wb1_en, prmiss, prsuccess, iss_en;
    logic        iss_valid, iss_dstval, iss_specbit, iss_s1s, iss_s2s, iss_lohi;
    logic [31:0] iss_src1, iss_src2;
    logic [5:0]  iss_dst;
    logic [4:0]  iss_spectag;
    logic [W-1:0] act_pkt;

    always #5 clk = ~clk;

    rs_mul_station dut (
        .clk(clk), .reset(reset),
        .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_src1(dp_src1), .dp_src2(dp_src2),
        .dp_rdy1(dp_rdy1), .dp_rdy2(dp_rdy2), .dp_dst(dp_dst), .dp_dstval(dp_dstval),
        .dp_spectag(dp_spectag), .dp_specbit(dp_specbit), .dp_s1s(dp_s1s), .dp_s2s(dp_s2s),
        .dp_lohi(dp_lohi), .wb0_en(wb0_en), .wb0_tag(wb0_tag), .wb0_data(wb0_data),
        .wb1_en(wb1_en), .wb1_tag(wb1_tag), .wb1_data(wb1_data), .prmiss(prmiss),
        .prsuccess(prsuccess), .spectagfix(spectagfix), .iss_en(iss_en), .iss_valid(iss_valid),
        .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_dst(iss_dst), .iss_dstval(iss_dstval),
        .iss_spectag(iss_spectag), .iss_specbit(iss_specbit), .iss_s1s(iss_s1s),
        .iss_s2s(iss_s2s), .iss_lohi(iss_lohi)
    );

    assign act_pkt = {iss_src1, iss_src2, iss_dst, iss_dstval, iss_spectag, iss_specbit,
                      iss_s1s, iss_s2s, iss_lohi};

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          v;
        bit          r1;
        bit          r2;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [5:0]  dst;
        bit          dstval;
        logic [4:0]  tag;
        bit          sb;
        bit          s1s;
        bit          s2s;
        bit          lohi;
    } ent_t;

    ent_t         m [NE];
    bit           exp_dp_ready, exp_iss_valid;
    int           exp_idx;
    logic [W-1:0] exp_pkt;

    function automatic bit killed(input bit sb, input logic [4:0] tag);
        return prmiss && sb && ((tag & spectagfix) != 5'd0);
    endfunction

    function automatic bit confirmed(input logic [4:0] tag);
        return !prmiss && prsuccess && ((tag & spectagfix) != 5'd0);
    endfunction

    function automatic void wake(inout bit r, inout logic [31:0] s);
        if (!r && wb0_en && wb0_tag == s[5:0]) begin r = 1; s = wb0_data; end
        else if (!r && wb1_en && wb1_tag == s[5:0]) begin r = 1; s = wb1_data; end
    endfunction

    function automatic logic [W-1:0] pack(input ent_t e);
        return {e.s1, e.s2, e.dst, e.dstval, e.tag, e.sb, e.s1s, e.s2s, e.lohi};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NE; i++) m[i] = '{default: '0};
    endfunction

    function automatic void model_eval();
        bit found = 0;
        exp_dp_ready = 0;
        exp_idx = 0;
        exp_pkt = '0;
        for (int i = 0; i < NE; i++) if (!m[i].v) exp_dp_ready = 1;
        for (int i = 0; i < NE && !found; i++)
            if (m[i].v && m[i].r1 && m[i].r2 && !killed(m[i].sb, m[i].tag)) begin
                found = 1;
                exp_idx = i;
            end
        exp_iss_valid = iss_en && found;
        if (exp_iss_valid) exp_pkt = pack(m[exp_idx]);
    endfunction

    function automatic void model_commit();
        ent_t nxt [NE];
        ent_t e;
        int   free_idx = -1;
        model_eval();
        for (int i = NE - 1; i >= 0; i--) if (!m[i].v) free_idx = i;
        nxt = m;
        for (int i = 0; i < NE; i++) begin
            if (!m[i].v) continue;
            if (killed(m[i].sb, m[i].tag) || (exp_iss_valid && exp_idx == i)) begin
                nxt[i].v = 0;
            end else begin
                wake(nxt[i].r1, nxt[i].s1);
                wake(nxt[i].r2, nxt[i].s2);
                if (confirmed(m[i].tag)) nxt[i].sb = 0;
            end
        end
        if (dp_valid && free_idx >= 0 && !killed(dp_specbit, dp_spectag)) begin
            e = '{v: 1, r1: dp_rdy1, r2: dp_rdy2, s1: dp_src1, s2: dp_src2, dst: dp_dst,
                  dstval: dp_dstval, tag: dp_spectag, sb: dp_specbit && !confirmed(dp_spectag),
                  s1s: dp_s1s, s2s: dp_s2s, lohi: dp_lohi};
            wake(e.r1, e.s1);
            wake(e.r2, e.s2);
            nxt[free_idx] = e;
        end
        m = nxt;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        dp_valid = 0; dp_src1 = 0; dp_src2 = 0; dp_rdy1 = 0; dp_rdy2 = 0; dp_dst = 0;
        dp_dstval = 0; dp_spectag = 0; dp_specbit = 0; dp_s1s = 0; dp_s2s = 0; dp_lohi = 0;
        wb0_en = 0; wb0_tag = 0; wb0_data = 0; wb1_en = 0; wb1_tag = 0; wb1_data = 0;
        prmiss = 0; prsuccess = 0; spectagfix = 0; iss_en = 0;
    endtask

    task automatic set_dp(input logic [31:0] s1, input bit r1, input logic [31:0] s2, input bit r2,
                          input logic [4:0] tag, input bit sb);
        dp_valid = 1; dp_src1 = s1; dp_rdy1 = r1; dp_src2 = s2; dp_rdy2 = r2;
        dp_spectag = tag; dp_specbit = sb;
        dp_dst = 6'($urandom_range(0, 63)); dp_dstval = 1'($urandom_range(0, 1));
        dp_s1s = 1'($urandom_range(0, 1)); dp_s2s = 1'($urandom_range(0, 1));
        dp_lohi = 1'($urandom_range(0, 1));
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        reset = 1;
        @(negedge clk); #1;
        vectors++; if (iss_valid !== 1'b0) begin miscompares++; $display("FAIL reset_iss_valid: got %b want 0", iss_valid); end
        vectors++; if (dp_ready !== 1'b1) begin miscompares++; $display("FAIL reset_dp_ready: got %b want 1", dp_ready); end
        vectors++; if (act_pkt !== '0) begin miscompares++; $display("FAIL reset_iss_fields: got %h want 0", act_pkt); end
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_dp(32'h05, 0, 32'h1, 1, 5'b00001, 0);
        tick();
        set_dp(32'h2, 1, 32'h06, 0, 5'b00001, 0);
        tick();
        idle(); #1; model_eval();
        vectors++; if (dp_ready !== 1'b0 || exp_dp_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_full: got %b want 0", dp_ready); end
        reset = 1; #1;
        model_reset();
        vectors++; if (iss_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_iss_valid: got %b want 0", iss_valid); end
        vectors++; if (dp_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_dp_ready: got %b want 1", dp_ready); end
        @(negedge clk);
        reset = 0;
        wb0_en = 1; wb0_tag = 6'h05; wb0_data = 32'hA5; wb1_en = 1; wb1_tag = 6'h06; wb1_data = 32'h5A; iss_en = 1;
        tick();
        idle(); iss_en = 1; #1; model_eval();
        vectors++; if (iss_valid !== 1'b0 || iss_valid !== exp_iss_valid) begin miscompares++; $display("FAIL midrst_gone: got iss_valid %b want 0", iss_valid); end
        tick();
    endtask

    task automatic test_basic_issue();
        do_reset();
        iss_en = 1; set_dp(32'd7, 1, 32'd6, 1, 5'b00001, 0); #1; model_eval();
        vectors++; if (iss_valid !== 1'b0) begin miscompares++; $display("FAIL basic_dispatch_cycle: got iss_valid %b want 0", iss_valid); end
        tick();
        idle(); iss_en = 1; #1; model_eval();
        vectors++; if (iss_valid !== 1'b1 || iss_src1 !== 32'd7 || iss_src2 !== 32'd6) begin miscompares++; $display("FAIL basic_issue: got v=%b s1=%h s2=%h want v=1 s1=7 s2=6", iss_valid, iss_src1, iss_src2); end
        vectors++; if (act_pkt !== exp_pkt) begin miscompares++; $display("FAIL basic_fields: got %h want %h", act_pkt, exp_pkt); end
        vectors++; if (dp_ready !== 1'b1) begin miscompares++; $display("FAIL basic_dp_ready: got %b want 1", dp_ready); end
        tick();
        #1;
        vectors++; if (iss_valid !== 1'b0) begin miscompares++; $display("FAIL basic_freed: got iss_valid %b want 0", iss_valid); end
    endtask

    task automatic test_bypass();
        do_reset();
        iss_en = 1; set_dp(32'h3, 1, 32'h0A, 0, 5'b00001, 0);
        wb1_en = 1; wb1_tag = 6'h0A; wb1_data = 32'h55; #1;
        vectors++; if (iss_valid !== 1'b0) begin miscompares++; $display("FAIL bypass_dispatch_cycle: got iss_valid %b want 0", iss_valid); end
        tick();
        idle(); iss_en = 1; #1; model_eval();
        vectors++; if (iss_valid !== 1'b1 || iss_src2 !== 32'h55) begin miscompares++; $display("FAIL bypass_issue: got v=%b s2=%h want v=1 s2=55", iss_valid, iss_src2); end
        vectors++; if (act_pkt !== exp_pkt) begin miscompares++; $display("FAIL bypass_fields: got %h want %h", act_pkt, exp_pkt); end
        tick();
    endtask

    task automatic test_full();
        do_reset();
        iss_en = 1; set_dp(32'h11, 0, 32'h1, 1, 5'b00001, 0); tick();
        set_dp(32'h2, 1, 32'h13, 0, 5'b00001, 0); tick();
        set_dp(32'hAA, 1, 32'hBB, 1, 5'b00001, 0);
        wb0_en = 1; wb0_tag = 6'h13; wb0_data = 32'h99; #1; model_eval();
        vectors++; if (dp_ready !== 1'b0) begin miscompares++; $display("FAIL full_dp_ready: got %b want 0", dp_ready); end
        vectors++; if (iss_valid !== 1'b0) begin miscompares++; $display("FAIL full_no_issue: got %b want 0", iss_valid); end
        tick();
        wb0_en = 0; #1; model_eval();
        vectors++; if (iss_valid !== 1'b1 || iss_src1 !== 32'h2 || iss_src2 !== 32'h99) begin miscompares++; $display("FAIL full_wake_issue: got v=%b s1=%h s2=%h want v=1 s1=2 s2=99", iss_valid, iss_src1, iss_src2); end
        vectors++; if (dp_ready !== 1'b0) begin miscompares++; $display("FAIL full_free_delay: got %b want 0", dp_ready); end
        tick();
        #1; model_eval();
        vectors++; if (dp_ready !== 1'b1) begin miscompares++; $display("FAIL full_reopen: got %b want 1", dp_ready); end
        vectors++; if (iss_valid !== 1'b0 || iss_valid !== exp_iss_valid) begin miscompares++; $display("FAIL full_held_dropped: got iss_valid %b want 0", iss_valid); end
        tick();
    endtask

    task automatic test_kill_success();
        do_reset();
        set_dp(32'h11, 1, 32'h12, 1, 5'b00010, 1); tick();
        set_dp(32'h21, 1, 32'h2C, 0, 5'b00100, 1); tick();
        idle(); iss_en = 1; prmiss = 1; spectagfix = 5'b00010; #1; model_eval();
        vectors++; if (iss_valid !== 1'b0 || exp_iss_valid !== 1'b0) begin miscompares++; $display("FAIL kill_blocks_issue: got %b want 0", iss_valid); end
        tick();
        idle(); iss_en = 1; #1; model_eval();
        vectors++; if (iss_valid !== 1'b0) begin miscompares++; $display("FAIL kill_dropped: got iss_valid %b want 0", iss_valid); end
        vectors++; if (dp_ready !== 1'b1) begin miscompares++; $display("FAIL kill_freed: got dp_ready %b want 1", dp_ready); end
        prsuccess = 1; spectagfix = 5'b00100;
        tick();
        idle(); iss_en = 1; wb0_en = 1; wb0_tag = 6'h2C; wb0_data = 32'h77; #1;
        vectors++; if (iss_valid !== 1'b0) begin miscompares++; $display("FAIL succ_wait: got iss_valid %b want 0", iss_valid); end
        tick();
        idle(); iss_en = 1; #1; model_eval();
        vectors++; if (iss_valid !== 1'b1 || iss_specbit !== 1'b0 || iss_src2 !== 32'h77 || iss_spectag !== 5'b00100) begin miscompares++; $display("FAIL succ_issue: got v=%b sb=%b s2=%h tag=%b want v=1 sb=0 s2=77 tag=00100", iss_valid, iss_specbit, iss_src2, iss_spectag); end
        vectors++; if (act_pkt !== exp_pkt) begin miscompares++; $display("FAIL succ_fields: got %h want %h", act_pkt, exp_pkt); end
        tick();
        set_dp(32'h31, 1, 32'h32, 1, 5'b01000, 1); tick();
        idle(); iss_en = 1; prsuccess = 1; spectagfix = 5'b01000; #1;
        vectors++; if (iss_valid !== 1'b1 || iss_specbit !== 1'b1) begin miscompares++; $display("FAIL succ_old_specbit: got v=%b sb=%b want v=1 sb=1", iss_valid, iss_specbit); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        iss_en = 1; set_dp(32'h41, 1, 32'h42, 1, 5'b00001, 0); tick();
        set_dp(32'h51, 1, 32'h52, 1, 5'b00001, 0); #1;
        vectors++; if (iss_valid !== 1'b1 || iss_src1 !== 32'h41) begin miscompares++; $display("FAIL b2b_first: got v=%b s1=%h want v=1 s1=41", iss_valid, iss_src1); end
        tick();
        idle(); iss_en = 1; #1;
        vectors++; if (iss_valid !== 1'b1 || iss_src1 !== 32'h51) begin miscompares++; $display("FAIL b2b_second: got v=%b s1=%h want v=1 s1=51", iss_valid, iss_src1); end
        tick();
    endtask

    task automatic test_random();
        int r;
        logic [W-1:0] want;
        do_reset();
        exp_q.delete();
        for (int n = 0; n < 600; n++) begin
            idle();
            if ($urandom_range(0, 99) < 70)
                set_dp(($urandom() & 32'hFFFF_FFC0) | 32'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       ($urandom() & 32'hFFFF_FFC0) | 32'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       5'(1 << $urandom_range(0, 4)), 1'($urandom_range(0, 1)));
            wb0_en = ($urandom_range(0, 99) < 35); wb0_tag = 6'($urandom_range(0, 7)); wb0_data = $urandom();
            wb1_en = ($urandom_range(0, 99) < 35); wb1_tag = 6'($urandom_range(0, 7)); wb1_data = $urandom();
            r = $urandom_range(0, 99);
            prmiss = (r < 5); prsuccess = (r >= 5 && r < 13);
            spectagfix = 5'(1 << $urandom_range(0, 4));
            iss_en = ($urandom_range(0, 99) < 75);
            #1; model_eval();
            vectors++; if (dp_ready !== exp_dp_ready) begin miscompares++; $display("FAIL rand_dp_ready[%0d]: got %b want %b", n, dp_ready, exp_dp_ready); end
            vectors++; if (iss_valid !== exp_iss_valid) begin miscompares++; $display("FAIL rand_iss_valid[%0d]: got %b want %b", n, iss_valid, exp_iss_valid); end
            if (exp_iss_valid) exp_q.push_back(exp_pkt);
            if (iss_valid === 1'b1 && exp_q.size() > 0) begin
                want = exp_q.pop_front();
                vectors++; if (act_pkt !== want) begin miscompares++; $display("FAIL rand_fields[%0d]: got %h want %h", n, act_pkt, want); end
            end
            tick();
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL rand_queue_left: got %0d pending want 0", exp_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_mid_reset();
        test_basic_issue();
        test_bypass();
        test_full();
        test_kill_success();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
